alu_issue_ctrl: RTL and testbench

Sequencing front end for the 32-bit ALU. Accepts RISC-V style operation requests (funct3/funct7, R/I class, operands, tag) over a valid/ready handshake. Encodes each request into the ALU's 4-bit control code, drives and holds the ALU operands for one cycle, then captures result and zero flag into a response register with its own valid/ready handshake. Sits between the determinant datapath controller and the ALU.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_op_decode.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 91 +++++++++
 tb/tb_alu_issue_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, funct7 constants and issue FSM state encoding.
package alu_pkg;
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLTU    = 4'b1000;
  localparam logic [3:0] ALU_SRA     = 4'b1001;
  localparam logic [3:0] ALU_MUL     = 4'b1010;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: {rtype, funct3, funct7} to ALU control code; MUL decode only when ALU_MUL_EN is defined.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic       rtype_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);
  logic base, alt, ok, mul;
  assign base = funct7_i == F7_BASE;
  assign alt  = funct7_i == F7_ALT;
  // I-type funct7 is immediate bits, so only R-type non-shift ops check it
  assign ok   = !rtype_i || base;
`ifdef ALU_MUL_EN
  assign mul = rtype_i && funct3_i == 3'b000 && funct7_i == F7_MUL;
`else
  assign mul = 1'b0;
`endif
  always_comb begin
    ctrl_o = ALU_ILLEGAL;
    case (funct3_i)
      3'b000: ctrl_o = mul ? ALU_MUL : (rtype_i && alt) ? ALU_SUB : ok ? ALU_ADD : ALU_ILLEGAL;
      3'b001: ctrl_o = base ? ALU_SLL : ALU_ILLEGAL;
      3'b010: ctrl_o = ok ? ALU_SLT : ALU_ILLEGAL;
      3'b011: ctrl_o = ok ? ALU_SLTU : ALU_ILLEGAL;
      3'b100: ctrl_o = ok ? ALU_XOR : ALU_ILLEGAL;
      3'b101: ctrl_o = base ? ALU_SRL : alt ? ALU_SRA : ALU_ILLEGAL;
      3'b110: ctrl_o = ok ? ALU_OR : ALU_ILLEGAL;
      default: ctrl_o = ok ? ALU_AND : ALU_ILLEGAL;
    endcase
  end
  assign illegal_o = ctrl_o == ALU_ILLEGAL;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready issue front end for the 32-bit ALU (IDLE -> EXEC -> RESP).
// Optional MUL decode via ALU_MUL_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rtype,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_zero,
  output logic             resp_illegal,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      op_count
);
  state_e state_q, state_d;
  logic [3:0] dec_ctrl;
  logic dec_illegal, ill_q, resp_zero_q, resp_illegal_q;
  logic [31:0] alu_a_q, alu_b_q, resp_result_q, op_count_q;
  logic [3:0] alu_ctrl_q;
  logic [TAG_W-1:0] tag_q, resp_tag_q;
  alu_op_decode u_dec (
    .rtype_i  (req_rtype),
    .funct3_i (req_funct3),
    .funct7_i (req_funct7),
    .ctrl_o   (dec_ctrl),
    .illegal_o(dec_illegal)
  );
  assign req_ready = state_q == ST_IDLE && !reset;
  always_comb begin
    state_d = state_q == ST_IDLE ? (req_valid ? ST_EXEC : ST_IDLE) :
              state_q == ST_EXEC ? ST_RESP : (resp_ready ? ST_IDLE : ST_RESP);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= ALU_ILLEGAL;
      ill_q          <= 1'b0;
      tag_q          <= '0;
      resp_result_q  <= '0;
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_tag_q     <= '0;
      op_count_q     <= '0;
    end else begin
      if (req_valid && req_ready) begin
        alu_a_q    <= req_a;
        alu_b_q    <= req_b;
        alu_ctrl_q <= dec_ctrl;
        ill_q      <= dec_illegal;
        tag_q      <= req_tag;
      end
      if (state_q == ST_EXEC) begin
        resp_result_q  <= ill_q ? '0 : alu_result;
        resp_zero_q    <= !ill_q && alu_zero;
        resp_illegal_q <= ill_q;
        resp_tag_q     <= tag_q;
        if (!ill_q) op_count_q <= op_count_q + 32'd1;
      end
    end
  end
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign resp_valid   = state_q == ST_RESP;
  assign resp_result  = resp_result_q;
  assign resp_zero    = resp_zero_q;
  assign resp_illegal = resp_illegal_q;
  assign resp_tag     = resp_tag_q;
  assign op_count     = op_count_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against alu_issue_ctrl with a behavioral ALU attached.
module tb_alu_issue_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_rtype = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [6:0] req_funct7 = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0] req_tag = '0;
  logic [31:0] alu_a, alu_b, alu_result, resp_result, op_count;
  logic [3:0] alu_ctrl, resp_tag;
  logic alu_zero, resp_valid, resp_ready = 1'b1, resp_zero, resp_illegal;
  int checks = 0, errors = 0;
  logic [31:0] exp_cnt = '0;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rtype(req_rtype), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_illegal(resp_illegal), .resp_tag(resp_tag),
    .op_count(op_count)
  );

  // illegal code yields a nonzero result with zero set so that masking is observable
  always_comb begin
    alu_result = 32'hDEADBEEF;
    case (alu_ctrl)
      4'h0: alu_result = alu_a & alu_b;
      4'h1: alu_result = alu_a | alu_b;
      4'h2: alu_result = alu_a + alu_b;
      4'h3: alu_result = alu_a ^ alu_b;
      4'h4: alu_result = alu_a << alu_b[4:0];
      4'h5: alu_result = alu_a >> alu_b[4:0];
      4'h6: alu_result = alu_a - alu_b;
      4'h7: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'h8: alu_result = {31'd0, alu_a < alu_b};
      4'h9: alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'hA: alu_result = alu_a * alu_b;
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = alu_ctrl == 4'hF ? 1'b1 : alu_result == 32'd0;
  end

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tg, got, exp);
    end
  endtask

  task automatic run_op(input logic rt, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                        input logic [3:0] ec, input logic [31:0] er, input logic ez,
                        input logic ei, input int hold);
    @(negedge clk);
    req_valid = 1'b1; req_rtype = rt; req_funct3 = f3; req_funct7 = f7;
    req_a = a; req_b = b; req_tag = tg; resp_ready = (hold == 0);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ec});
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("req_ready_exec", {31'd0, req_ready}, 32'd0);
    chk("resp_valid_exec", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    if (!ei) exp_cnt++;
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_result", resp_result, er);
    chk("resp_zero", {31'd0, resp_zero}, {31'd0, ez});
    chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, ei});
    chk("resp_tag", {28'd0, resp_tag}, {28'd0, tg});
    chk("op_count", op_count, exp_cnt);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_result", resp_result, er);
      chk("hold_zero", {31'd0, resp_zero}, {31'd0, ez});
      chk("hold_tag", {28'd0, resp_tag}, {28'd0, tg});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_valid", {31'd0, resp_valid}, 32'd0);
    chk("retire_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    //     rt  f3      f7          a             b             tag   ctrl  result        z     ill   hold
    run_op(1, 3'b000, 7'b0000000, 32'd5,        32'd7,        4'd3, 4'h2, 32'd12,       1'b0, 1'b0, 0);
    run_op(1, 3'b000, 7'b0100000, 32'd9,        32'd9,        4'd5, 4'h6, 32'd0,        1'b1, 1'b0, 5);
    run_op(0, 3'b101, 7'b0100000, 32'h80000000, 32'd4,        4'd6, 4'h9, 32'hF8000000, 1'b0, 1'b0, 0);
    run_op(0, 3'b101, 7'b0000000, 32'h80000000, 32'd4,        4'd7, 4'h5, 32'h08000000, 1'b0, 1'b0, 0);
    if (MUL_ON)
      run_op(1, 3'b000, 7'b0000001, 32'd6, 32'd7, 4'd8, 4'hA, 32'd42, 1'b0, 1'b0, 0);
    else
      run_op(1, 3'b000, 7'b0000001, 32'd6, 32'd7, 4'd8, 4'hF, 32'd0,  1'b0, 1'b1, 0);
    run_op(1, 3'b101, 7'b0010000, 32'd1,        32'd1,        4'd9, 4'hF, 32'd0,        1'b0, 1'b1, 0);
    run_op(0, 3'b000, 7'b0100000, 32'd10,       32'hFFFFFFFD, 4'd1, 4'h2, 32'd7,        1'b0, 1'b0, 0);
    run_op(1, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1,        4'd2, 4'h7, 32'd1,        1'b0, 1'b0, 0);
    run_op(1, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1,        4'd4, 4'h8, 32'd0,        1'b1, 1'b0, 0);
    run_op(1, 3'b100, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 4'd0, 4'h3, 32'h00000FF0, 1'b0, 1'b0, 0);
    run_op(0, 3'b110, 7'b1111111, 32'd0,        32'hFFFFFFFF, 4'hA, 4'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_op(1, 3'b111, 7'b0000000, 32'hFF,       32'h0F,       4'hB, 4'h0, 32'h0F,       1'b0, 1'b0, 0);
    run_op(1, 3'b111, 7'b0100000, 32'hFF,       32'h0F,       4'hC, 4'hF, 32'd0,        1'b0, 1'b1, 0);
    run_op(0, 3'b001, 7'b0000000, 32'd1,        32'd31,       4'hD, 4'h4, 32'h80000000, 1'b0, 1'b0, 0);
    run_op(0, 3'b001, 7'b0000001, 32'd1,        32'd3,        4'hE, 4'hF, 32'd0,        1'b0, 1'b1, 0);
    run_op(1, 3'b001, 7'b0100000, 32'd1,        32'd3,        4'hF, 4'hF, 32'd0,        1'b0, 1'b1, 0);
    run_op(1, 3'b010, 7'b0000001, 32'd1,        32'd3,        4'h1, 4'hF, 32'd0,        1'b0, 1'b1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_rtype = 1'b1; req_funct3 = 3'b000; req_funct7 = 7'd0;
    req_a = 32'd1; req_b = 32'd1; req_tag = 4'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_exec_ctrl", {28'd0, alu_ctrl}, 32'h2);
    reset = 1'b1; #1;
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_resp_result", resp_result, 32'd0);
    chk("abort_resp_tag", {28'd0, resp_tag}, 32'd0);
    chk("abort_op_count", op_count, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    exp_cnt = '0;
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    run_op(1, 3'b000, 7'b0000000, 32'd2, 32'd3, 4'd4, 4'h2, 32'd5, 1'b0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
